// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage and its next-PC helper.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'b00,
        S_EXEC = 2'b01,
        S_HALT = 2'b10
    } fetch_state_e;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    // Branch displacement is a signed word count; convert to a byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage (master) and memory (slave).
interface fetch_unit_if;

    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: jump, taken branch, or sequential; reused by the pipelined fetch.
module next_pc_calc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic        i_is_jump,
    input  logic        i_is_branch,
    input  logic        i_branch_taken,
    input  logic [15:0] i_imm16,
    input  logic [25:0] i_addr26,
    output logic [31:0] o_next_pc
);

    logic [31:0] w_pc4;

    assign w_pc4 = i_pc + PC_STEP;

    always_comb begin
        // NOTE: default first so every path assigns the output and no latch is inferred.
        o_next_pc = w_pc4;
        if (i_is_jump) begin
            o_next_pc = {w_pc4[31:28], i_addr26, 2'b00};
        end else if (i_is_branch && i_branch_taken) begin
            o_next_pc = w_pc4 + branch_offset(i_imm16);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, imem req/ack fetch FSM, valid/ready hand-off to the decoder.
// Optional imem timeout with sticky fault is enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
`ifdef FETCH_TIMEOUT_EN
    parameter int          TIMEOUT  = 16,
`endif
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_unit_if.master       imem,
    output logic [31:0]        o_instruction,
    output logic               o_instr_valid,
    input  logic               i_instr_ready,
    input  logic               i_is_jump,
    input  logic               i_is_branch,
    input  logic               i_branch_taken,
    input  logic [15:0]        i_imm16,
    input  logic [25:0]        i_addr26,
    output logic [31:0]        o_pc,
    output logic [CNT_W-1:0]   o_retire_count,
    output logic               o_fault
);

    fetch_state_e     r_state;
    fetch_state_e     w_next_state;
    logic             r_req;
    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic [CNT_W-1:0] r_retire;
    logic [31:0]      w_next_pc;
    logic             w_accept;
    logic             w_commit;
    logic             w_timeout;

    next_pc_calc u_next_pc (
        .i_pc           (r_pc),
        .i_is_jump      (i_is_jump),
        .i_is_branch    (i_is_branch),
        .i_branch_taken (i_branch_taken),
        .i_imm16        (i_imm16),
        .i_addr26       (i_addr26),
        .o_next_pc      (w_next_pc)
    );

    // r_req is only ever set while in S_REQ, so it also qualifies ack.
    assign w_accept = r_req & imem.ack;
    assign w_commit = (r_state == S_EXEC) & i_instr_ready;

`ifdef FETCH_TIMEOUT_EN
    localparam int WAIT_W = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;

    logic [WAIT_W-1:0] r_wait;

    // Ack on the TIMEOUT-th request cycle wins over the timeout.
    assign w_timeout = r_req & ~imem.ack & (r_wait == WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait <= '0;
        end else if (r_state != S_REQ) begin
            r_wait <= '0;
        end else if (r_req && !imem.ack) begin
            r_wait <= r_wait + WAIT_W'(1);
        end
    end

    assign o_fault = (r_state == S_HALT);
`else
    assign w_timeout = 1'b0;
    assign o_fault   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_REQ;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_REQ: begin
                if (w_accept) begin
                    w_next_state = S_EXEC;
                end else if (w_timeout) begin
                    w_next_state = S_HALT;
                end
            end
            S_EXEC:  if (w_commit) w_next_state = S_REQ;
            S_HALT:  w_next_state = S_HALT;
            default: w_next_state = S_REQ;
        endcase
    end

    // The request is registered so it is low during reset and the cycle after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req    <= 1'b0;
            r_pc     <= RESET_PC;
            r_instr  <= INSTR_NOP;
            r_retire <= '0;
        end else begin
            r_req <= (w_next_state == S_REQ);
            if (w_accept) begin
                r_instr <= imem.rdata;
            end
            if (w_commit) begin
                r_pc <= w_next_pc;
                if (r_retire != '1) begin
                    r_retire <= r_retire + CNT_W'(1);
                end
            end
        end
    end

    assign imem.req       = r_req;
    assign imem.addr      = r_pc;
    assign o_instruction  = r_instr;
    assign o_instr_valid  = (r_state == S_EXEC);
    assign o_pc           = r_pc;
    assign o_retire_count = r_retire;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed PC-arithmetic vectors plus randomized
// handshake delays and decoder fields against a behavioural PC/retire model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          CNT_W    = 3;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;
`ifdef FETCH_TIMEOUT_EN
    localparam int          TIMEOUT  = 16;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [31:0]      instruction;
    logic             instr_valid;
    logic             instr_ready;
    logic             is_jump;
    logic             is_branch;
    logic             branch_taken;
    logic [15:0]      imm16;
    logic [25:0]      addr26;
    logic [31:0]      pc;
    logic [CNT_W-1:0] retire_count;
    logic             fault;

    fetch_unit_if imem_bus ();

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (imem_bus),
        .o_instruction  (instruction),
        .o_instr_valid  (instr_valid),
        .i_instr_ready  (instr_ready),
        .i_is_jump      (is_jump),
        .i_is_branch    (is_branch),
        .i_branch_taken (branch_taken),
        .i_imm16        (imm16),
        .i_addr26       (addr26),
        .o_pc           (pc),
        .o_retire_count (retire_count),
        .o_fault        (fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] m_pc;
    int          m_cnt;
    logic [31:0] m_instr;

    // Reference: MIPS next-PC rules in plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic j, input logic b,
                                             input logic t, input logic [15:0] imm,
                                             input logic [25:0] a26);
        logic [31:0] pc4;
        int          off;
        pc4 = cur + 32'd4;
        off = $signed(imm);
        if (j) return {pc4[31:28], a26, 2'b00};
        if (b && t) return pc4 + 32'(off * 4);
        return pc4;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_decoder();
        is_jump      = 1'($urandom());
        is_branch    = 1'($urandom());
        branch_taken = 1'($urandom());
        imm16        = 16'($urandom());
        addr26       = 26'($urandom());
    endtask

    task automatic model_reset();
        m_pc  = RESET_PC;
        m_cnt = 0;
    endtask

    // Fetch one word with ack_delay idle request cycles before the ack.
    task automatic do_fetch(input int ack_delay);
        logic [31:0] data;
        int          waited = 0;
        while (imem_bus.req !== 1'b1 && waited < 4) begin
            tick();
            waited++;
        end
        n_total++;
        if (imem_bus.req !== 1'b1 || imem_bus.addr !== m_pc)
            $display("FAIL fetch_req: req=%b addr=%h, expected req=1 addr=%h", imem_bus.req, imem_bus.addr, m_pc);
        else n_pass++;
        repeat (ack_delay) begin
            tick();
            n_total++;
            if (imem_bus.req !== 1'b1 || imem_bus.addr !== m_pc || instr_valid !== 1'b0)
                $display("FAIL fetch_stall: req=%b addr=%h valid=%b, expected 1 %h 0", imem_bus.req, imem_bus.addr, instr_valid, m_pc);
            else n_pass++;
        end
        data           = $urandom();
        imem_bus.ack   = 1'b1;
        imem_bus.rdata = data;
        tick();
        imem_bus.ack   = 1'b0;
        imem_bus.rdata = $urandom();
        m_instr        = data;
        n_total++;
        if (instr_valid !== 1'b1 || instruction !== data || imem_bus.req !== 1'b0)
            $display("FAIL fetch_data: valid=%b instr=%h req=%b, expected 1 %h 0", instr_valid, instruction, imem_bus.req, data);
        else n_pass++;
    endtask

    // Commit the held word after ready_delay cycles with the given decoder fields.
    task automatic do_commit(input int ready_delay, input logic j, input logic b, input logic t,
                             input logic [15:0] imm, input logic [25:0] a26);
        is_jump = j; is_branch = b; branch_taken = t; imm16 = imm; addr26 = a26;
        repeat (ready_delay) begin
            tick();
            n_total++;
            if (instr_valid !== 1'b1 || instruction !== m_instr || imem_bus.req !== 1'b0 || pc !== m_pc)
                $display("FAIL exec_hold: valid=%b instr=%h req=%b pc=%h, expected 1 %h 0 %h", instr_valid, instruction, imem_bus.req, pc, m_instr, m_pc);
            else n_pass++;
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        m_pc  = ref_next(m_pc, j, b, t, imm, a26);
        m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
        scramble_decoder();
        n_total++;
        if (instr_valid !== 1'b0 || imem_bus.req !== 1'b1 || imem_bus.addr !== m_pc || pc !== m_pc)
            $display("FAIL commit_next: valid=%b req=%b addr=%h pc=%h, expected 0 1 %h", instr_valid, imem_bus.req, imem_bus.addr, pc, m_pc);
        else n_pass++;
        n_total++;
        if (retire_count !== CNT_W'(m_cnt) || fault !== 1'b0)
            $display("FAIL commit_count: retire=%0d fault=%b, expected %0d 0", retire_count, fault, m_cnt);
        else n_pass++;
    endtask

    task automatic check_const_pc(input string tag, input logic [31:0] exp);
        n_total++;
        if (imem_bus.addr !== exp) $display("FAIL %s: addr=%h expected %h", tag, imem_bus.addr, exp);
        else n_pass++;
    endtask

    task automatic check_reset_outputs(input string tag);
        n_total++;
        if (imem_bus.req !== 1'b0 || instr_valid !== 1'b0 || fault !== 1'b0)
            $display("FAIL %s_ctl: req=%b valid=%b fault=%b, expected 0 0 0", tag, imem_bus.req, instr_valid, fault);
        else n_pass++;
        n_total++;
        if (pc !== RESET_PC || imem_bus.addr !== RESET_PC || instruction !== 32'h0 || retire_count !== '0)
            $display("FAIL %s_data: pc=%h addr=%h instr=%h retire=%0d, expected %h %h 0 0", tag, pc, imem_bus.addr, instruction, retire_count, RESET_PC, RESET_PC);
        else n_pass++;
    endtask

    task automatic test_reset();
        imem_bus.ack = 1'b0; imem_bus.rdata = '0; instr_ready = 1'b0;
        scramble_decoder();
        rst_n = 1'b0;
        tick(); tick();
        check_reset_outputs("reset_hold");
        rst_n = 1'b1;
        model_reset();
        do_fetch(0);
        do_commit(0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("reset_async");
        tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_sequential();
        int start;
        int w = 0;
        while (imem_bus.req !== 1'b1 && w < 4) begin
            tick();
            w++;
        end
        start = cyc;
        for (int i = 0; i < 4; i++) begin
            check_const_pc("seq_addr", 32'(i * 4));
            do_fetch(0);
            do_commit(0, 1'b0, 1'b0, 1'b0, 16'($urandom()), 26'($urandom()));
        end
        n_total++;
        if (retire_count !== CNT_W'(4) || cyc - start !== 8)
            $display("FAIL seq_rate: retire=%0d cycles=%0d, expected 4 8", retire_count, cyc - start);
        else n_pass++;
    endtask

    task automatic test_branch_jump();
        do_fetch(0); do_commit(0, 1'b1, 1'b0, 1'b0, 16'h1234, 26'h000_0040);
        check_const_pc("jump_0x100", 32'h0000_0100);
        do_fetch(0); do_commit(0, 1'b0, 1'b1, 1'b1, 16'hFFFE, 26'h3FF_FFFF);
        check_const_pc("branch_taken", 32'h0000_00FC);
        do_fetch(0); do_commit(0, 1'b0, 1'b0, 1'b1, 16'hFFFE, 26'h0);
        check_const_pc("seq_to_0x100", 32'h0000_0100);
        do_fetch(0); do_commit(0, 1'b0, 1'b1, 1'b0, 16'hFFFE, 26'h0);
        check_const_pc("branch_not_taken", 32'h0000_0104);
        do_fetch(0); do_commit(0, 1'b1, 1'b1, 1'b1, 16'h0010, 26'h000_0080);
        check_const_pc("jump_priority", 32'h0000_0200);
    endtask

    task automatic test_stall_wrap();
        do_fetch(1); do_commit(2, 1'b1, 1'b0, 1'b0, 16'h0, 26'h0);
        check_const_pc("jump_zero", 32'h0000_0000);
        do_fetch(5); do_commit(3, 1'b0, 1'b1, 1'b1, 16'hFFFE, 26'h0);
        check_const_pc("branch_below_zero", 32'hFFFF_FFFC);
        do_fetch(2); do_commit(1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        check_const_pc("pc_wrap", 32'h0000_0000);
        do_fetch(0); do_commit(0, 1'b0, 1'b1, 1'b1, 16'hFFFB, 26'h0);
        check_const_pc("branch_back", 32'hFFFF_FFF0);
        do_fetch(0); do_commit(0, 1'b1, 1'b0, 1'b0, 16'h0, 26'h000_0040);
        check_const_pc("jump_high_nibble", 32'hF000_0100);
    endtask

    task automatic test_ignored_inputs();
        instr_ready = 1'b1;
        tick(); tick();
        instr_ready = 1'b0;
        n_total++;
        if (pc !== m_pc || retire_count !== CNT_W'(m_cnt) || instr_valid !== 1'b0 || imem_bus.req !== 1'b1)
            $display("FAIL ready_in_req: pc=%h retire=%0d valid=%b req=%b, expected %h %0d 0 1", pc, retire_count, instr_valid, imem_bus.req, m_pc, m_cnt);
        else n_pass++;
        do_fetch(0);
        imem_bus.ack = 1'b1; imem_bus.rdata = ~m_instr;
        tick();
        imem_bus.ack = 1'b0;
        n_total++;
        if (instruction !== m_instr || instr_valid !== 1'b1)
            $display("FAIL ack_in_exec: instr=%h valid=%b, expected %h 1", instruction, instr_valid, m_instr);
        else n_pass++;
        do_commit(0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_fetch(int'($urandom_range(0, 4)));
            do_commit(int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                      1'($urandom()), 16'($urandom()), 26'($urandom()));
        end
        n_total++;
        if (retire_count !== CNT_W'(CNT_MAX))
            $display("FAIL retire_saturate: retire=%0d expected %0d", retire_count, CNT_MAX);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int w = 0;
        while (imem_bus.req !== 1'b1 && w < 4) begin
            tick();
            w++;
        end
`ifdef FETCH_TIMEOUT_EN
        for (int k = 2; k <= TIMEOUT; k++) begin
            tick();
            n_total++;
            if (imem_bus.req !== 1'b1 || fault !== 1'b0)
                $display("FAIL timeout_wait: cycle=%0d req=%b fault=%b, expected 1 0", k, imem_bus.req, fault);
            else n_pass++;
        end
        repeat (6) begin
            tick();
            n_total++;
            if (imem_bus.req !== 1'b0 || fault !== 1'b1 || instr_valid !== 1'b0 || pc !== m_pc)
                $display("FAIL timeout_halt: req=%b fault=%b valid=%b pc=%h, expected 0 1 0 %h", imem_bus.req, fault, instr_valid, pc, m_pc);
            else n_pass++;
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        n_total++;
        if (fault !== 1'b0) $display("FAIL timeout_reset: fault=%b expected 0", fault);
        else n_pass++;
        do_fetch(TIMEOUT - 1);
        do_commit(0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
`else
        repeat (30) begin
            tick();
            n_total++;
            if (imem_bus.req !== 1'b1 || fault !== 1'b0 || imem_bus.addr !== m_pc)
                $display("FAIL no_timeout: req=%b fault=%b addr=%h, expected 1 0 %h", imem_bus.req, fault, imem_bus.addr, m_pc);
            else n_pass++;
        end
        do_fetch(0);
        do_commit(0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch_jump();
        test_stall_wrap();
        test_ignored_inputs();
        test_random();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
